// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: control bit positions, payload layout and
// the stage's main-register load selector.
package pipe_pkg;

    localparam int IDEX_CTRL_W = 9;
    localparam int IDEX_DATA_W = 143;

    localparam int CTRL_WB_EN       = 0;
    localparam int CTRL_MEM_W_EN    = 1;
    localparam int CTRL_MEM_R_EN    = 2;
    localparam int CTRL_BR_TAKEN    = 3;
    localparam int CTRL_EXE_CMD_LSB = 4;
    localparam int CTRL_EXE_CMD_W   = 5;

    localparam int PAY_PC_LSB   = 0;
    localparam int PAY_VAL1_LSB = 32;
    localparam int PAY_VAL2_LSB = 64;
    localparam int PAY_REG2_LSB = 96;
    localparam int PAY_DEST_LSB = 128;
    localparam int PAY_SRC2_LSB = 133;
    localparam int PAY_SRC1_LSB = 138;

    typedef struct packed {
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic [31:0] reg2;
        logic [31:0] val2;
        logic [31:0] val1;
        logic [31:0] pc;
    } idex_data_t;

    typedef enum logic [1:0] {
        LOAD_HOLD,
        LOAD_SKID,
        LOAD_INPUT,
        LOAD_BUBBLE
    } load_sel_e;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with optional skid entry, bubble insertion,
// flush, and saturating stall/bubble counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hazard,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam bit HAS_SKID = (SKID != 0);

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic      main_free;
    logic      in_fire;
    load_sel_e load_sel;

    assign main_free = !out_valid_q || out_ready;

    // With a skid entry, ready depends only on registered state plus the
    // hazard/flush controls, so no path runs from out_ready to in_ready.
    assign in_ready = HAS_SKID ? (!skid_valid_q && !hazard && !flush)
                               : (main_free && !hazard && !flush);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        load_sel     = LOAD_HOLD;

        if (main_free) begin
            if (skid_valid_q)  load_sel = LOAD_SKID;
            else if (in_fire)  load_sel = LOAD_INPUT;
            else               load_sel = LOAD_BUBBLE;
        end

        case (load_sel)
            LOAD_SKID: begin
                out_valid_d  = 1'b1;
                out_ctrl_d   = skid_ctrl_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
            LOAD_INPUT: begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end
            LOAD_BUBBLE: begin
                out_valid_d = 1'b0;
                out_ctrl_d  = '0;
                out_data_d  = '0;
            end
            default: ;
        endcase

        if (HAS_SKID && !main_free && in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end

        // Flush overrides everything loaded above, including the dropped input.
        if (flush) begin
            out_valid_d  = 1'b0;
            out_ctrl_d   = '0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            skid_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= '0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid_q && !out_ready),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard && !flush),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboarded bench: a SKID=1 default stage plus a SKID=0, CNT_W=4 stage for
// combinational-ready and counter saturation scenarios.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CW = IDEX_CTRL_W;
    localparam int DW = IDEX_DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, hazard, flush, out_valid, out_ready, cnt_clr;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [15:0]   stall_cnt, bubble_cnt;

    logic          b_in_valid, b_in_ready, b_hazard, b_flush, b_out_valid, b_out_ready, b_cnt_clr;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [3:0]    b_stall_cnt, b_bubble_cnt;

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .hazard(hazard), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.SKID(0), .CNT_W(4)) dut_ns (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .hazard(b_hazard), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .cnt_clr(b_cnt_clr), .stall_cnt(b_stall_cnt),
        .bubble_cnt(b_bubble_cnt)
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } item_t;

    item_t sb_q[$];
    item_t mon_e;
    int    total = 0;
    int    bad   = 0;

    function automatic logic [CW-1:0] mk_ctrl(input logic [31:0] pc);
        return {pc[6:2], 4'b1001};
    endfunction

    function automatic logic [DW-1:0] mk_data(input logic [31:0] pc);
        idex_data_t d;
        d.src1 = pc[6:2];
        d.src2 = pc[7:3];
        d.dest = pc[8:4];
        d.reg2 = ~pc;
        d.val2 = pc * 32'd3;
        d.val1 = pc + 32'h1000;
        d.pc   = pc;
        return d;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_ctrl  = v ? mk_ctrl(pc) : '0;
        in_data  = v ? mk_data(pc) : '0;
    endtask

    task automatic bdrive(input logic v, input logic [31:0] pc);
        b_in_valid = v;
        b_in_ctrl  = v ? mk_ctrl(pc) : '0;
        b_in_data  = v ? mk_data(pc) : '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted inputs are queued, every output transfer is popped
    // and compared; flush and reset discard everything resident.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got pc=%h, nothing expected", out_data[31:0]);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (out_ctrl !== mon_e.ctrl || out_data !== mon_e.data) begin
                        bad++;
                        $display("FAIL sb_order: got pc=%h ctrl=%h want pc=%h ctrl=%h",
                                 out_data[31:0], out_ctrl, mon_e.data[31:0], mon_e.ctrl);
                    end
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(item_t'({in_ctrl, in_data}));
        end
        if (out_valid === 1'b0) begin
            total++;
            if (out_ctrl !== '0 || out_data !== '0) begin
                bad++;
                $display("FAIL idle_zero: got ctrl=%h data_pc=%h want 0", out_ctrl, out_data[31:0]);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0); hazard = 0; flush = 0; out_ready = 1; cnt_clr = 0;
        bdrive(1'b0, 32'h0); b_hazard = 0; b_flush = 0; b_out_ready = 1; b_cnt_clr = 0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_out: got v=%b ctrl=%h want 0", out_valid, out_ctrl);
        end
        total++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: got stall=%0d bubble=%0d want 0", stall_cnt, bubble_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, b_in_ready);
        end
        step();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, 32'(4 * k));
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_in_ready: cycle %0d got %b want 1", k, in_ready);
            end
            total++;
            if (k == 0 && out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stream_latency: got out_valid=%b want 0 before first edge", out_valid);
            end else if (k > 0 && (out_valid !== 1'b1 || out_data[31:0] !== 32'(4 * (k - 1)))) begin
                bad++;
                $display("FAIL stream_out: cycle %0d got v=%b pc=%h want v=1 pc=%h",
                         k, out_valid, out_data[31:0], 32'(4 * (k - 1)));
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] pcs [8];
        logic        ivs [8];
        logic        ors [8];
        logic [31:0] exp_pc [8];
        logic        exp_rdy [8];
        pcs     = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'h0};
        ivs     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ors     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_pc  = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8, 32'hC};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            drive(ivs[k], pcs[k]);
            out_ready = ors[k];
            cnt_clr   = (k == 0);
            @(negedge clk);
            total++;
            if (in_ready !== exp_rdy[k]) begin
                bad++;
                $display("FAIL stall_in_ready: cycle %0d got %b want %b", k, in_ready, exp_rdy[k]);
            end
            if (k > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_data[31:0] !== exp_pc[k]) begin
                    bad++;
                    $display("FAIL stall_out: cycle %0d got v=%b pc=%h want v=1 pc=%h",
                             k, out_valid, out_data[31:0], exp_pc[k]);
                end
            end
            step();
        end
        cnt_clr = 0;
        @(negedge clk);
        total++;
        if (stall_cnt !== 16'd3) begin
            bad++;
            $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
        end
        step();
    endtask

    task automatic test_hazard();
        logic [31:0] pcs [5];
        logic        ivs [5];
        logic        hzs [5];
        logic        exp_rdy [5];
        logic        exp_v [5];
        logic [31:0] exp_pc [5];
        pcs     = '{32'h20, 32'h24, 32'h24, 32'h24, 32'h0};
        ivs     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        hzs     = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_v   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_pc  = '{32'h0, 32'h20, 32'h0, 32'h0, 32'h24};
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            drive(ivs[k], pcs[k]);
            hazard  = hzs[k];
            cnt_clr = (k == 0);
            @(negedge clk);
            total++;
            if (in_ready !== exp_rdy[k]) begin
                bad++;
                $display("FAIL hazard_in_ready: cycle %0d got %b want %b", k, in_ready, exp_rdy[k]);
            end
            total++;
            if (out_valid !== exp_v[k] || out_data[31:0] !== exp_pc[k]) begin
                bad++;
                $display("FAIL hazard_out: cycle %0d got v=%b pc=%h want v=%b pc=%h",
                         k, out_valid, out_data[31:0], exp_v[k], exp_pc[k]);
            end
            step();
        end
        cnt_clr = 0;
        hazard  = 0;
        @(negedge clk);
        total++;
        if (bubble_cnt !== 16'd2) begin
            bad++;
            $display("FAIL bubble_cnt: got %0d want 2", bubble_cnt);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
        step();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h40); out_ready = 0;
        step();
        drive(1'b1, 32'h44);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data[31:0] !== 32'h40) begin
            bad++;
            $display("FAIL flush_setup: got rdy=%b v=%b pc=%h want 1 1 40", in_ready, out_valid, out_data[31:0]);
        end
        step();
        drive(1'b1, 32'h48); flush = 1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        step();
        drive(1'b0, 32'h0); flush = 0; out_ready = 1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL flush_out: got v=%b ctrl=%h want 0", out_valid, out_ctrl);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_skid: got in_ready=%b want 1", in_ready);
        end
        step();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_residue: got out_valid=%b pc=%h want 0", out_valid, out_data[31:0]);
        end
        step();
    endtask

    task automatic test_noskid_sat();
        bdrive(1'b1, 32'h80); b_out_ready = 1; b_cnt_clr = 1;
        @(negedge clk);
        total++;
        if (b_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ns_in_ready0: got %b want 1", b_in_ready);
        end
        step();
        bdrive(1'b1, 32'h84); b_cnt_clr = 0;
        @(negedge clk);
        total++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b1 || b_out_data !== mk_data(32'h80)) begin
            bad++;
            $display("FAIL ns_tput: got rdy=%b v=%b pc=%h want 1 1 80", b_in_ready, b_out_valid, b_out_data[31:0]);
        end
        step();
        bdrive(1'b1, 32'h88); b_out_ready = 0;
        for (int s = 0; s < 23; s++) begin
            b_cnt_clr   = (s == 20);
            b_out_ready = (s == 22);
            @(negedge clk);
            if (s == 0 || s == 5) begin
                total++;
                if (b_in_ready !== 1'b0 || b_out_data[31:0] !== 32'h84) begin
                    bad++;
                    $display("FAIL ns_hold: step %0d got rdy=%b pc=%h want 0 84", s, b_in_ready, b_out_data[31:0]);
                end
            end
            if (s == 14 || s == 15 || s == 20) begin
                total++;
                if (b_stall_cnt !== ((s == 14) ? 4'd14 : 4'd15)) begin
                    bad++;
                    $display("FAIL ns_sat: step %0d got %0d want %0d", s, b_stall_cnt, (s == 14) ? 14 : 15);
                end
            end
            if (s == 21 || s == 22) begin
                total++;
                if (b_stall_cnt !== ((s == 21) ? 4'd0 : 4'd1)) begin
                    bad++;
                    $display("FAIL ns_clr: step %0d got %0d want %0d", s, b_stall_cnt, (s == 21) ? 0 : 1);
                end
            end
            if (s == 22) begin
                total++;
                if (b_in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL ns_release: got in_ready=%b want 1", b_in_ready);
                end
            end
            step();
        end
        bdrive(1'b0, 32'h0); b_out_ready = 1; b_cnt_clr = 0;
        @(negedge clk);
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== mk_data(32'h88) || b_out_ctrl !== mk_ctrl(32'h88)) begin
            bad++;
            $display("FAIL ns_last: got v=%b pc=%h want 1 88", b_out_valid, b_out_data[31:0]);
        end
        step();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h100); out_ready = 0;
        step();
        drive(1'b1, 32'h104);
        step();
        drive(1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL arst_out: got v=%b ctrl=%h pc=%h want 0", out_valid, out_ctrl, out_data[31:0]);
        end
        total++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            bad++;
            $display("FAIL arst_cnt: got stall=%0d bubble=%0d want 0", stall_cnt, bubble_cnt);
        end
        #3;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_hazard();
        test_flush();
        test_noskid_sat();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
